// File: rtl/request_arbiter_pkg.sv
// Shared constants and helpers for the request arbiter.
//   YES/NO, HIGH/LOW : single-bit truth and level constants
//   wrap_inc         : increment an index, wrapping modulo a channel count
package request_arbiter_pkg;

  localparam logic YES  = 1'b1;
  localparam logic NO   = 1'b0;
  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/request_arbiter_if.sv
// Handshake bundle between event sources / consumer and the request arbiter.
//   made            per-channel request pulse
//   taken           consumer acknowledges the current grant
//   overflow_clear  clears all sticky overflow flags
//   request         a grant is valid
//   request_channel granted channel index
//   pending         per-channel count != 0
//   overflow        sticky per-channel overflow
// master: the driving side (sources + consumer); slave: the arbiter.
interface request_arbiter_if #(
  parameter int unsigned CHANNELS = 4
) ();
  localparam int unsigned CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS-1:0]      made;
  logic                     taken;
  logic                     overflow_clear;
  logic                     request;
  logic [CHANNEL_WIDTH-1:0] request_channel;
  logic [CHANNELS-1:0]      pending;
  logic [CHANNELS-1:0]      overflow;

  modport master (
    output made, taken, overflow_clear,
    input  request, request_channel, pending, overflow
  );

  modport slave (
    input  made, taken, overflow_clear,
    output request, request_channel, pending, overflow
  );
endinterface

// File: rtl/request_counter.sv
// One channel's saturating up/down request counter with sticky overflow.
//   clk, reset      clock; asynchronous active-high reset
//   made            increment request
//   take            decrement request (channel's grant acknowledged)
//   overflow_clear  clears the sticky overflow flag
//   count           outstanding requests, 0..DEPTH
//   overflow        set when a made is dropped at DEPTH
module request_counter
  import request_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH       = 1,
  parameter int unsigned COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   made,
  input  logic                   take,
  input  logic                   overflow_clear,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);
  localparam logic [COUNT_WIDTH-1:0] Max = COUNT_WIDTH'(DEPTH);

  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic                   sat;

  always_comb begin
    count_d = count_q;
    sat     = NO;
    if (made && !take) begin
      if (count_q == Max) sat = YES;
      else                count_d = count_q + COUNT_WIDTH'(1);
    end else if (!made && take && count_q != '0) begin
      count_d = count_q - COUNT_WIDTH'(1);
    end
    // A fresh overflow beats a same-cycle clear.
    overflow_d = sat | (overflow_q & ~overflow_clear);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      overflow_q <= NO;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
endmodule

// File: rtl/request_arbiter.sv
// Multi-channel request arbiter: per-channel request counters feeding a
// round-robin grant presented to a single consumer.
//   clk, reset  clock; asynchronous active-high reset
//   bus         request_arbiter_if.slave (made/taken/overflow_clear in,
//               request/request_channel/pending/overflow out)
module request_arbiter
  import request_arbiter_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 1
) (
  input logic               clk,
  input logic               reset,
  request_arbiter_if.slave  bus
);
  localparam int unsigned COUNT_WIDTH   = $clog2(DEPTH + 1);
  localparam int unsigned CHANNEL_WIDTH = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [COUNT_WIDTH-1:0]   count [CHANNELS];
  logic [CHANNELS-1:0]      take, nz_next, ovf;
  logic                     request_q;
  logic [CHANNEL_WIDTH-1:0] request_channel_q;
  logic [CHANNEL_WIDTH-1:0] ptr_q, ptr_d, pick;
  logic [CHANNELS-1:0]      pending_q, shifted;
  logic                     found, reload;
  int unsigned              idx;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign take[i] = bus.taken && request_q && (request_channel_q == CHANNEL_WIDTH'(i));

    request_counter #(
      .DEPTH       (DEPTH),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
      .clk            (clk),
      .reset          (reset),
      .made           (bus.made[i]),
      .take           (take[i]),
      .overflow_clear (bus.overflow_clear),
      .count          (count[i]),
      .overflow       (ovf[i])
    );

    // Post-update count is nonzero; mirrors the counter's next-state rules.
    assign nz_next[i] = bus.made[i] | (count[i] > COUNT_WIDTH'(1)) |
                        ((count[i] == COUNT_WIDTH'(1)) & ~take[i]);
  end

  always_comb begin
    ptr_d = ptr_q;
    if (bus.taken && request_q) begin
      ptr_d = CHANNEL_WIDTH'(wrap_inc(32'(request_channel_q), CHANNELS));
    end
  end

  // Round-robin search over post-update counts starting at the updated
  // pointer, so an acknowledged channel goes to the back of the line.
  always_comb begin
    found   = NO;
    pick    = '0;
    idx     = 0;
    shifted = '0;
    for (int unsigned j = 0; j < CHANNELS; j++) begin
      idx = 32'(ptr_d) + j;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      shifted = nz_next >> idx;
      if (!found && shifted[0]) begin
        found = YES;
        pick  = CHANNEL_WIDTH'(idx);
      end
    end
  end

  assign reload = !request_q || bus.taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      request_q         <= NO;
      request_channel_q <= '0;
      ptr_q             <= '0;
      pending_q         <= '0;
    end else begin
      ptr_q     <= ptr_d;
      pending_q <= nz_next;
      if (reload) begin
        request_q         <= found;
        request_channel_q <= pick;
      end
    end
  end

  assign bus.request         = request_q;
  assign bus.request_channel = request_channel_q;
  assign bus.pending         = pending_q;
  assign bus.overflow        = ovf;
endmodule

// File: tb/tb_request_arbiter.sv
// Scenario bench for request_arbiter: three instances cover the
// single-latch case (1x1), a 4-channel depth-1 arbiter and a 4-channel
// depth-3 arbiter. Expected grant order is queued when requests are made
// and popped as each grant is acknowledged.
module tb_request_arbiter;
  logic clk = 1'b0;
  logic rst1, rst4, rst3;
  int   n_checks = 0;
  int   n_fail   = 0;
  int unsigned exp_q[$];
  int unsigned exp_ch;

  always #5 clk = ~clk;

  request_arbiter_if #(.CHANNELS(1)) bus1 ();
  request_arbiter_if #(.CHANNELS(4)) bus4 ();
  request_arbiter_if #(.CHANNELS(4)) bus3 ();

  request_arbiter #(.CHANNELS(1), .DEPTH(1)) dut1 (.clk(clk), .reset(rst1), .bus(bus1));
  request_arbiter #(.CHANNELS(4), .DEPTH(1)) dut4 (.clk(clk), .reset(rst4), .bus(bus4));
  request_arbiter #(.CHANNELS(4), .DEPTH(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3));

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1; rst3 = 1'b1;
    bus1.made = '0; bus1.taken = 1'b0; bus1.overflow_clear = 1'b0;
    bus4.made = '0; bus4.taken = 1'b0; bus4.overflow_clear = 1'b0;
    bus3.made = '0; bus3.taken = 1'b0; bus3.overflow_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst1 = 1'b0; rst4 = 1'b0; rst3 = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus1.request, bus1.pending, bus1.overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_1x1: got req/pend/ovf %b%b%b, expected 000",
               bus1.request, bus1.pending, bus1.overflow);
    end
    n_checks++;
    if ({bus4.request, bus4.request_channel, bus4.pending, bus4.overflow} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_4x1: got req=%b ch=%0d pend=%b ovf=%b, expected all zero",
               bus4.request, bus4.request_channel, bus4.pending, bus4.overflow);
    end
    n_checks++;
    if ({bus3.request, bus3.request_channel, bus3.pending, bus3.overflow} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_4x3: got req=%b ch=%0d pend=%b ovf=%b, expected all zero",
               bus3.request, bus3.request_channel, bus3.pending, bus3.overflow);
    end
  endtask

  // Single-latch behaviour: made@c0, taken@c3, stray taken@c5.
  task automatic test_single_latch();
    bus1.made = 1'b1;
    @(negedge clk);
    bus1.made = 1'b0;
    n_checks++;
    if ({bus1.request, bus1.pending} !== 2'b11) begin
      n_fail++;
      $display("FAIL single_set: got req=%b pend=%b, expected 1 1", bus1.request, bus1.pending);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus1.request !== 1'b1) begin
      n_fail++;
      $display("FAIL single_hold: got req=%b, expected 1", bus1.request);
    end
    bus1.taken = 1'b1;
    @(negedge clk);
    bus1.taken = 1'b0;
    n_checks++;
    if ({bus1.request, bus1.pending} !== 2'b00) begin
      n_fail++;
      $display("FAIL single_taken: got req=%b pend=%b, expected 0 0", bus1.request, bus1.pending);
    end
    @(negedge clk);
    bus1.taken = 1'b1;
    @(negedge clk);
    bus1.taken = 1'b0;
    n_checks++;
    if ({bus1.request, bus1.pending, bus1.overflow} !== 3'b000) begin
      n_fail++;
      $display("FAIL single_stray_taken: got req/pend/ovf %b%b%b, expected 000",
               bus1.request, bus1.pending, bus1.overflow);
    end
  endtask

  // made=1011 at once: grants 0,1,3 with no gap between them.
  task automatic test_round_robin();
    bus4.made = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    @(negedge clk);
    bus4.made = '0;
    while (exp_q.size() > 0) begin
      exp_ch = exp_q.pop_front();
      n_checks++;
      if (bus4.request !== 1'b1 || 32'(bus4.request_channel) !== exp_ch) begin
        n_fail++;
        $display("FAIL rr_grant: got req=%b ch=%0d, expected req=1 ch=%0d",
                 bus4.request, bus4.request_channel, exp_ch);
      end
      bus4.taken = 1'b1;
      @(negedge clk);
      bus4.taken = 1'b0;
    end
    n_checks++;
    if ({bus4.request, bus4.pending} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL rr_drained: got req=%b pend=%b, expected 0 0000", bus4.request, bus4.pending);
    end
  endtask

  // Depth 3, four back-to-back made on ch2: saturates and flags overflow.
  task automatic test_saturate();
    bus3.made = 4'b0100;
    repeat (4) @(negedge clk);
    bus3.made = '0;
    repeat (3) exp_q.push_back(2);
    n_checks++;
    if (bus3.overflow !== 4'b0100 || bus3.pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL sat_overflow: got ovf=%b pend=%b, expected 0100 0100",
               bus3.overflow, bus3.pending);
    end
    while (exp_q.size() > 0) begin
      exp_ch = exp_q.pop_front();
      n_checks++;
      if (bus3.request !== 1'b1 || 32'(bus3.request_channel) !== exp_ch) begin
        n_fail++;
        $display("FAIL sat_grant: got req=%b ch=%0d, expected req=1 ch=%0d",
                 bus3.request, bus3.request_channel, exp_ch);
      end
      bus3.taken = 1'b1;
      @(negedge clk);
      bus3.taken = 1'b0;
    end
    n_checks++;
    if ({bus3.request, bus3.pending} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL sat_drained: got req=%b pend=%b, expected 0 0000 (count exceeded 3?)",
               bus3.request, bus3.pending);
    end
    bus3.overflow_clear = 1'b1;
    @(negedge clk);
    bus3.overflow_clear = 1'b0;
  endtask

  // made and taken on the granted channel in the same cycle at depth 1.
  task automatic test_made_and_taken();
    bus4.made = 4'b0010;
    @(negedge clk);
    bus4.made  = 4'b0010;
    bus4.taken = 1'b1;
    @(negedge clk);
    bus4.made  = '0;
    bus4.taken = 1'b0;
    n_checks++;
    if (bus4.request !== 1'b1 || bus4.request_channel !== 2'd1 ||
        bus4.pending !== 4'b0010 || bus4.overflow !== 4'b0000) begin
      n_fail++;
      $display("FAIL made_taken: got req=%b ch=%0d pend=%b ovf=%b, expected 1 1 0010 0000",
               bus4.request, bus4.request_channel, bus4.pending, bus4.overflow);
    end
    bus4.taken = 1'b1;
    @(negedge clk);
    bus4.taken = 1'b0;
    n_checks++;
    if (bus4.request !== 1'b0) begin
      n_fail++;
      $display("FAIL made_taken_drain: got req=%b, expected 0", bus4.request);
    end
  endtask

  // Overflow event wins over a same-cycle clear; a lone clear drops the flag.
  task automatic test_overflow_clear();
    bus4.made = 4'b0100;
    repeat (2) @(negedge clk);
    bus4.made = '0;
    n_checks++;
    if (bus4.overflow !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b, expected 0100", bus4.overflow);
    end
    bus4.made = 4'b0100;
    bus4.overflow_clear = 1'b1;
    @(negedge clk);
    bus4.made = '0;
    n_checks++;
    if (bus4.overflow !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovf_clear_race: got ovf=%b, expected 0100", bus4.overflow);
    end
    @(negedge clk);
    bus4.overflow_clear = 1'b0;
    n_checks++;
    if (bus4.overflow !== 4'b0000) begin
      n_fail++;
      $display("FAIL ovf_clear_alone: got ovf=%b, expected 0000", bus4.overflow);
    end
    bus4.taken = 1'b1;
    @(negedge clk);
    bus4.taken = 1'b0;
    n_checks++;
    if ({bus4.request, bus4.pending} !== 5'b0_0000) begin
      n_fail++;
      $display("FAIL ovf_drain: got req=%b pend=%b, expected 0 0000", bus4.request, bus4.pending);
    end
  endtask

  // Counts {2,0,1,3}, then reset raised between edges clears at once.
  task automatic test_async_reset();
    bus3.made = 4'b1101;
    @(negedge clk);
    bus3.made = 4'b1001;
    @(negedge clk);
    bus3.made = 4'b1000;
    @(negedge clk);
    bus3.made = '0;
    n_checks++;
    if (bus3.pending !== 4'b1101 || bus3.request !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre: got pend=%b req=%b, expected 1101 1", bus3.pending, bus3.request);
    end
    #2;
    rst3 = 1'b1;
    #1;
    n_checks++;
    if ({bus3.request, bus3.request_channel, bus3.pending, bus3.overflow} !== 11'd0) begin
      n_fail++;
      $display("FAIL areset_async: got req=%b ch=%0d pend=%b ovf=%b, expected all zero",
               bus3.request, bus3.request_channel, bus3.pending, bus3.overflow);
    end
    @(negedge clk);
    rst3 = 1'b0;
    bus3.made = 4'b0010;
    exp_q.push_back(1);
    @(negedge clk);
    bus3.made = '0;
    exp_ch = exp_q.pop_front();
    n_checks++;
    if (bus3.request !== 1'b1 || 32'(bus3.request_channel) !== exp_ch ||
        bus3.pending !== 4'b0010) begin
      n_fail++;
      $display("FAIL areset_post: got req=%b ch=%0d pend=%b, expected 1 %0d 0010",
               bus3.request, bus3.request_channel, bus3.pending, exp_ch);
    end
  endtask

  initial begin
    test_reset();
    test_single_latch();
    test_round_robin();
    test_saturate();
    test_made_and_taken();
    test_overflow_clear();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
